// File: rtl/pm32_arb_pkg.sv
// Shared types and constants for the pm32 multiplier round-robin scheduler.
package pm32_arb_pkg;
  localparam int MUL_W       = 32;
  localparam int PROD_W      = 64;
  localparam int TIMEOUT_DEF = 80;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    RESP,
    ABORT
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr (mod NREQ).
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [ID_W-1:0] o_idx
);
  always_comb begin
    logic        w_found;
    int unsigned j;
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < unsigned'(NREQ); k++) begin
      j = (32'(i_ptr) + k) % unsigned'(NREQ);
      if (i_en && !w_found && i_req[j]) begin
        w_found  = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = ID_W'(j);
      end
    end
  end
endmodule

// File: rtl/pm32_arbiter.sv
// Round-robin scheduler sharing one serial signed 32x32 multiplier among NREQ
// requesters; returns tagged products (or timeout errors) on one response channel.
module pm32_arbiter
  import pm32_arb_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = TIMEOUT_DEF,
  localparam int ID_W    = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*MUL_W-1:0]  req_mc,
  input  logic [NREQ*MUL_W-1:0]  req_mp,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [PROD_W-1:0]      rsp_p,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   mul_rst,
  output logic                   mul_start,
  output logic [MUL_W-1:0]       mul_mc,
  output logic [MUL_W-1:0]       mul_mp,
  input  logic [PROD_W-1:0]      mul_p,
  input  logic                   mul_done
);
  localparam int CNT_W = $clog2(TIMEOUT);

  state_t            r_state, w_next;
  logic [ID_W-1:0]   r_ptr, r_id, w_gidx;
  logic [NREQ-1:0]   w_gnt;
  logic [MUL_W-1:0]  r_mc, r_mp;
  logic [PROD_W-1:0] r_p;
  logic              r_err, r_abort;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_en, w_hs, w_tmo;

  // Grant is also masked by rst_n so req_ready reads 0 while reset is held.
  assign w_en  = rst_n && (r_state == IDLE);
  assign w_hs  = |w_gnt;
  assign w_tmo = (r_cnt == CNT_W'(TIMEOUT - 1));

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .i_en  (w_en),
    .o_gnt (w_gnt),
    .o_idx (w_gidx)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_hs) w_next = START;
      START:   w_next = WAIT;
      WAIT:    if (mul_done) w_next = RESP;
               else if (w_tmo) w_next = ABORT;
      ABORT:   w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_mc    <= '0;
      r_mp    <= '0;
      r_p     <= '0;
      r_err   <= 1'b0;
      r_abort <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_abort <= 1'b0;
      unique case (r_state)
        IDLE: if (w_hs) begin
          r_mc  <= req_mc[w_gidx*MUL_W +: MUL_W];
          r_mp  <= req_mp[w_gidx*MUL_W +: MUL_W];
          r_id  <= w_gidx;
          r_ptr <= (w_gidx == ID_W'(NREQ - 1)) ? '0 : w_gidx + ID_W'(1);
        end
        START: r_cnt <= '0;
        WAIT: begin
          if (mul_done) begin
            r_p   <= mul_p;
            r_err <= 1'b0;
          end else if (w_tmo) begin
            r_p     <= '0;
            r_err   <= 1'b1;
            r_abort <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = w_gnt;
  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_id;
  assign rsp_p     = r_p;
  assign rsp_err   = r_err;
  assign busy      = (r_state != IDLE);
  assign mul_rst   = ~rst_n | r_abort;
  assign mul_start = (r_state == START);
  assign mul_mc    = r_mc;
  assign mul_mp    = r_mp;
endmodule

// File: tb/tb_pm32_arbiter.sv
// Directed scoreboard bench for pm32_arbiter with a behavioural serial multiplier.
module tb_pm32_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 80;
  localparam int LAT     = 66;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_mc;
  logic [NREQ*32-1:0] req_mp;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [63:0]       rsp_p;
  logic              rsp_err;
  logic              busy;
  logic              mul_rst;
  logic              mul_start;
  logic [31:0]       mul_mc;
  logic [31:0]       mul_mp;
  logic [63:0]       mul_p;
  logic              mul_done;

  pm32_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mc    (req_mc),
    .req_mp    (req_mp),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .mul_rst   (mul_rst),
    .mul_start (mul_start),
    .mul_mc    (mul_mc),
    .mul_mp    (mul_mp),
    .mul_p     (mul_p),
    .mul_done  (mul_done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    longint r;
    r = longint'($signed(a)) * longint'($signed(b));
    return 64'(r);
  endfunction

  // Serial multiplier model: done rises LAT cycles after start, stays high until next start.
  logic m_hang;
  int   m_cnt;
  always @(posedge clk) begin
    if (mul_rst) begin
      mul_done <= 1'b0;
      mul_p    <= '0;
      m_cnt    <= 0;
    end else if (mul_start) begin
      mul_done <= 1'b0;
      m_cnt    <= m_hang ? 0 : LAT;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        mul_done <= 1'b1;
        mul_p    <= prod(mul_mc, mul_mp);
      end
    end
  end

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] p;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input logic [NREQ-1:0] v);
    req_valid = v;
    #1;
  endtask

  task automatic push(input int id, input logic [63:0] p, input logic err);
    exp_t e;
    e.id  = 2'(id);
    e.p   = p;
    e.err = err;
    q.push_back(e);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_busy"},  64'(busy),      64'd0);
    chk({tag, "_rspv"},  64'(rsp_valid), 64'd0);
    chk({tag, "_rdy"},   64'(req_ready), 64'd0);
    chk({tag, "_start"}, 64'(mul_start), 64'd0);
    chk({tag, "_mrst"},  64'(mul_rst),   64'd1);
    chk({tag, "_mc"},    64'(mul_mc),    64'd0);
    chk({tag, "_mp"},    64'(mul_mp),    64'd0);
    chk({tag, "_p"},     rsp_p,          64'd0);
    chk({tag, "_err"},   64'(rsp_err),   64'd0);
    chk({tag, "_id"},    64'(rsp_id),    64'd0);
    tick();
    tick();
    chk({tag, "_mrst_hold"}, 64'(mul_rst), 64'd1);
    rst_n = 1'b1;
    #1;
    chk({tag, "_mrst_rel"}, 64'(mul_rst), 64'd0);
    q.delete();
  endtask

  task automatic wait_grant(input string tag, input logic [NREQ-1:0] exp, input int max_wait);
    int n;
    n = 0;
    while (req_ready == '0 && n < max_wait) begin
      tick();
      n++;
    end
    chk({tag, "_gnt"}, 64'(req_ready), 64'(exp));
  endtask

  // Called in the START cycle; counts cycles until rsp_valid.
  task automatic run_wait(input string tag, input logic [31:0] mc, input logic [31:0] mp,
                          input int exp_lat, input int exp_rst);
    int n, starts, rsts;
    n = 0; starts = 0; rsts = 0;
    chk({tag, "_start"}, 64'(mul_start), 64'd1);
    chk({tag, "_mc"},    64'(mul_mc),    64'(mc));
    chk({tag, "_mp"},    64'(mul_mp),    64'(mp));
    while (n < 200) begin
      tick();
      n++;
      if (mul_start) starts++;
      if (mul_rst) rsts++;
      if (rsp_valid) break;
    end
    chk({tag, "_lat"},    64'(n),      64'(exp_lat));
    chk({tag, "_xstart"}, 64'(starts), 64'd0);
    chk({tag, "_mrstn"},  64'(rsts),   64'(exp_rst));
    chk({tag, "_mchold"}, 64'(mul_mc), 64'(mc));
  endtask

  task automatic resp_check(input string tag, input int hold);
    exp_t e;
    chk({tag, "_sbq"}, 64'(q.size()), 64'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, "_rspv"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_id"},   64'(rsp_id),    64'(e.id));
      chk({tag, "_p"},    rsp_p,          e.p);
      chk({tag, "_err"},  64'(rsp_err),   64'(e.err));
      for (int i = 0; i < hold; i++) begin
        tick();
        chk({tag, "_hold_v"},   64'(rsp_valid), 64'd1);
        chk({tag, "_hold_p"},   rsp_p,          e.p);
        chk({tag, "_hold_id"},  64'(rsp_id),    64'(e.id));
        chk({tag, "_hold_rdy"}, 64'(req_ready), 64'd0);
      end
    end
  endtask

  task automatic hs(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_post_v"},    64'(rsp_valid), 64'd0);
    chk({tag, "_post_busy"}, 64'(busy),      64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mc, mp;
    int g;
    rst_n = 1'b1; req_valid = '0; req_mc = '0; req_mp = '0;
    rsp_ready = 1'b0; m_hang = 1'b0;
    #3;
    req_valid = 4'hF;
    do_reset("rst0");
    set_valid('0);
    tick();

    // -3 * 7
    mc = 32'hFFFF_FFFD; mp = 32'd7;
    req_mc[31:0] = mc; req_mp[31:0] = mp;
    set_valid(4'b0001);
    wait_grant("a", 4'b0001, 10);
    push(0, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    tick();
    req_valid = '0;
    run_wait("a", mc, mp, LAT + 2, 0);
    resp_check("a", 0);
    hs("a");

    req_valid = 4'hF;
    do_reset("rst1");

    for (int i = 0; i < NREQ; i++) begin
      req_mc[32*i +: 32] = $urandom;
      req_mp[32*i +: 32] = $urandom;
    end
    #1;
    for (int k = 0; k < 5; k++) begin
      g = k % NREQ;
      wait_grant($sformatf("rr%0d", k), 4'(1 << g), (k == 0) ? 10 : 0);
      chk($sformatf("rr%0d_onehot", k), 64'($onehot(req_ready)), 64'd1);
      mc = req_mc[32*g +: 32];
      mp = req_mp[32*g +: 32];
      push(g, prod(mc, mp), 1'b0);
      tick();
      if (k == 4) req_valid = '0;
      run_wait($sformatf("rr%0d", k), mc, mp, LAT + 2, 0);
      resp_check($sformatf("rr%0d", k), 2);
      hs($sformatf("rr%0d", k));
    end

    // Response back-pressure with another requester waiting.
    mc = 32'h7FFF_FFFF; mp = 32'h7FFF_FFFF;
    req_mc[95:64] = mc; req_mp[95:64] = mp;
    set_valid(4'b0100);
    wait_grant("hold", 4'b0100, 10);
    push(2, 64'h3FFF_FFFF_0000_0001, 1'b0);
    tick();
    req_valid = 4'b0001;
    run_wait("hold", mc, mp, LAT + 2, 0);
    resp_check("hold", 10);
    req_valid = '0;
    hs("hold");

    // Timeout, then a normal run.
    m_hang = 1'b1;
    mc = 32'h0000_1234; mp = 32'hFFFF_0001;
    req_mc[63:32] = mc; req_mp[63:32] = mp;
    set_valid(4'b0010);
    wait_grant("to", 4'b0010, 10);
    push(1, 64'd0, 1'b1);
    tick();
    req_valid = '0;
    run_wait("to", mc, mp, TIMEOUT + 2, 1);
    resp_check("to", 1);
    hs("to");
    m_hang = 1'b0;

    mc = 32'h8000_0000; mp = 32'h8000_0000;
    req_mc[127:96] = mc; req_mp[127:96] = mp;
    set_valid(4'b1000);
    wait_grant("post_to", 4'b1000, 10);
    push(3, 64'h4000_0000_0000_0000, 1'b0);
    tick();
    req_valid = '0;
    run_wait("post_to", mc, mp, LAT + 2, 0);
    resp_check("post_to", 0);
    hs("post_to");

    // Reset 30 cycles into WAIT.
    mc = 32'h0000_0055; mp = 32'h0000_0003;
    req_mc[95:64] = mc; req_mp[95:64] = mp;
    set_valid(4'b0100);
    wait_grant("mid", 4'b0100, 10);
    tick();
    req_valid = 4'b0110;
    repeat (31) tick();
    chk("mid_busy_pre", 64'(busy), 64'd1);
    do_reset("rst2");
    wait_grant("rst2_first", 4'b0010, 0);
    mc = req_mc[63:32]; mp = req_mp[63:32];
    push(1, prod(mc, mp), 1'b0);
    tick();
    req_valid = '0;
    run_wait("after_rst", mc, mp, LAT + 2, 0);
    resp_check("after_rst", 0);
    hs("after_rst");

    // mul_done is still high from the previous run across this START.
    chk("stale_done_pre", 64'(mul_done), 64'd1);
    mc = 32'hFFFF_FFFF; mp = 32'h0000_0002;
    req_mc[127:96] = mc; req_mp[127:96] = mp;
    set_valid(4'b1000);
    wait_grant("stale", 4'b1000, 10);
    push(3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    tick();
    req_valid = '0;
    run_wait("stale", mc, mp, LAT + 2, 0);
    resp_check("stale", 0);
    hs("stale");

    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
